// File: rtl/aurora_link_sequencer.sv
// rtl/aurora_link_sequencer.sv - Aurora link bring-up, loopback traffic test and retry sequencer
// Optional LINK_SEQ_AUTO_RESTART_EN: channel loss in LINKED re-runs bring-up instead of failing.
module aurora_link_sequencer #(
  parameter int RESET_CYCLES = 128,
  parameter int UP_TIMEOUT   = 65536,
  parameter int TEST_CYCLES  = 4096,
  parameter int MAX_RETRIES  = 3,
  parameter int ERR_LIMIT    = 1
) (
  input  logic       clk_200MHz,
  input  logic       peripheral_aresetn,
  input  logic       start,
  input  logic       channel_up,
  input  logic       frame_error,
  output logic       link_reset,
  output logic       test_enable,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [1:0] retry_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RESET_LINK = 3'd1,
    S_WAIT_UP    = 3'd2,
    S_TEST       = 3'd3,
    S_LINKED     = 3'd4,
    S_FAIL       = 3'd5
  } state_t;

  localparam int T_MAX = (UP_TIMEOUT > RESET_CYCLES)
                       ? ((UP_TIMEOUT > TEST_CYCLES) ? UP_TIMEOUT : TEST_CYCLES)
                       : ((RESET_CYCLES > TEST_CYCLES) ? RESET_CYCLES : TEST_CYCLES);
  localparam int TW = $clog2(T_MAX + 1);
  localparam logic [TW-1:0] T_RESET_LAST = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] T_UP_LAST    = TW'(UP_TIMEOUT - 1);
  localparam logic [TW-1:0] T_TEST_LAST  = TW'(TEST_CYCLES - 1);
  localparam logic [4:0]    ERR_LIM      = 5'(ERR_LIMIT);
  localparam logic [2:0]    RETRY_MAX    = 3'(MAX_RETRIES);

  state_t        state_q, next_state;
  logic [TW-1:0] timer;
  logic [1:0]    up_cnt;
  logic [3:0]    err_next;
  logic          attempt_fail, retry_ok, start_ok, test_entry, linked_restart;
  logic          link_reset_d, test_enable_d, done_d, pass_d;

  assign state      = state_q;
  assign retry_ok   = ({1'b0, retry_cnt} < RETRY_MAX);
  assign start_ok   = start && ((state_q == S_IDLE) || (state_q == S_FAIL));
  assign test_entry = (state_q != S_TEST) && (next_state == S_TEST);

  // Counting uses the registered test_enable so only TEST/LINKED cycles accumulate errors.
  always_comb begin
    err_next = err_cnt;
    if (test_enable && frame_error && (err_cnt != 4'hF))
      err_next = err_cnt + 4'd1;
  end

  always_comb begin
    next_state     = state_q;
    attempt_fail   = 1'b0;
    linked_restart = 1'b0;
    case (state_q)
      S_IDLE, S_FAIL: if (start) next_state = S_RESET_LINK;
      S_RESET_LINK:   if (timer == T_RESET_LAST) next_state = S_WAIT_UP;
      S_WAIT_UP: begin
        if (channel_up && (up_cnt == 2'd3)) next_state = S_TEST;
        else if (timer == T_UP_LAST)        attempt_fail = 1'b1;
      end
      S_TEST: begin
        if (!channel_up) attempt_fail = 1'b1;
        else if (timer == T_TEST_LAST) begin
          if ({1'b0, err_next} >= ERR_LIM) attempt_fail = 1'b1;
          else                             next_state = S_LINKED;
        end
      end
      S_LINKED: begin
        if (!channel_up) begin
`ifdef LINK_SEQ_AUTO_RESTART_EN
          next_state     = S_RESET_LINK;
          linked_restart = 1'b1;
`else
          next_state     = S_FAIL;
`endif
        end
      end
      default: next_state = S_IDLE;
    endcase
    if (attempt_fail) next_state = retry_ok ? S_RESET_LINK : S_FAIL;
  end

  // Outputs are decoded from next_state and registered, so they change together with state.
  always_comb begin
    link_reset_d  = 1'b0;
    test_enable_d = 1'b0;
    done_d        = 1'b0;
    pass_d        = 1'b0;
    case (next_state)
      S_IDLE, S_RESET_LINK: link_reset_d = 1'b1;
      S_TEST:               test_enable_d = 1'b1;
      S_LINKED: begin
        test_enable_d = 1'b1;
        done_d        = 1'b1;
        pass_d        = 1'b1;
      end
      S_FAIL: begin
        link_reset_d = 1'b1;
        done_d       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_200MHz or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      state_q     <= S_IDLE;
      link_reset  <= 1'b1;
      test_enable <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      state_q     <= next_state;
      link_reset  <= link_reset_d;
      test_enable <= test_enable_d;
      done        <= done_d;
      pass        <= pass_d;
    end
  end

  always_ff @(posedge clk_200MHz or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      timer     <= '0;
      up_cnt    <= 2'd0;
      err_cnt   <= 4'd0;
      retry_cnt <= 2'd0;
    end else begin
      if ((next_state == state_q) &&
          ((state_q == S_RESET_LINK) || (state_q == S_WAIT_UP) || (state_q == S_TEST)))
        timer <= timer + TW'(1);
      else
        timer <= '0;

      up_cnt <= ((state_q == S_WAIT_UP) && channel_up) ? up_cnt + 2'd1 : 2'd0;

      if (start_ok || test_entry) err_cnt <= 4'd0;
      else                        err_cnt <= err_next;

      if (start_ok || linked_restart)  retry_cnt <= 2'd0;
      else if (attempt_fail && retry_ok) retry_cnt <= retry_cnt + 2'd1;
    end
  end

endmodule

// File: doc/aurora_link_sequencer.md
AURORA_LINK_SEQUENCER -- requirements
Module: aurora_link_sequencer

Interface
REQ-001 Parameter RESET_CYCLES, default 128: cycles link_reset is held per bring-up attempt.
REQ-002 Parameter UP_TIMEOUT, default 65536: cycles allowed in WAIT_UP before the attempt fails.
REQ-003 Parameter TEST_CYCLES, default 4096: length of the loopback traffic test window.
REQ-004 Parameter MAX_RETRIES, default 3: failed attempts retried before entering FAIL.
REQ-005 Parameter ERR_LIMIT, default 1: err_cnt value at or above which a test window fails.
REQ-006 clk_200MHz  in  1  single clock; all logic on its rising edge.
REQ-007 peripheral_aresetn  in  1  asynchronous assert, active-low reset.
REQ-008 start  in  1  single-cycle pulse that begins bring-up from IDLE or FAIL.
REQ-009 channel_up  in  1  Aurora channel-up status, already synchronous to clk_200MHz.
REQ-010 frame_error  in  1  one-cycle pulse per frame-checker mismatch.
REQ-011 link_reset  out  1  active-high reset to the Aurora core and frame generator/checker.
REQ-012 test_enable  out  1  enables the frame generator and checker.
REQ-013 done  out  1  high in LINKED or FAIL.
REQ-014 pass  out  1  high only in LINKED.
REQ-015 err_cnt  out  4  frame-error count, saturating at 15.
REQ-016 retry_cnt  out  2  failed attempts in the current run.
REQ-017 state  out  3  encoding: IDLE=0, RESET_LINK=1, WAIT_UP=2, TEST=3, LINKED=4, FAIL=5.

Function
REQ-018 IDLE: link_reset=1 and test_enable=0; start moves to RESET_LINK and clears retry_cnt and err_cnt.
REQ-019 RESET_LINK: link_reset=1 for exactly RESET_CYCLES cycles, then WAIT_UP.
REQ-020 WAIT_UP: link_reset=0; channel_up high for 4 consecutive cycles moves to TEST; a low cycle restarts the debounce count.
REQ-021 WAIT_UP: timer reaching UP_TIMEOUT without a debounced channel_up counts as a failed attempt.
REQ-022 TEST: test_enable=1; err_cnt is cleared on entry; the window lasts exactly TEST_CYCLES cycles.
REQ-023 TEST: channel_up low in any cycle is a failed attempt; the attempt is abandoned immediately.
REQ-024 TEST end: err_cnt >= ERR_LIMIT is a failed attempt; otherwise the block moves to LINKED.
REQ-025 Failed attempt: if retry_cnt < MAX_RETRIES, retry_cnt increments and the block goes to RESET_LINK; otherwise it goes to FAIL.
REQ-026 LINKED: test_enable=1, done=1, pass=1; err_cnt continues counting; retry_cnt is held.
REQ-027 FAIL: link_reset=1, test_enable=0, done=1, pass=0; err_cnt and retry_cnt are held; start restarts as in REQ-018.
REQ-028 err_cnt increments only while test_enable=1; it saturates at 15 with no wrap.
REQ-029 If frame_error and channel_up low occur in the same TEST cycle, channel_up loss takes priority; err_cnt still increments.
REQ-030 start is ignored outside IDLE and FAIL.
REQ-031 All outputs are registered; a state change is visible on outputs the cycle after the decision edge.

Reset
REQ-032 peripheral_aresetn low asynchronously forces state=IDLE, link_reset=1, test_enable=0, done=0, pass=0, err_cnt=0, retry_cnt=0, and clears all timers.
REQ-033 Reset asserted mid-operation aborts any attempt; after deassertion the block waits in IDLE for start.

Configuration
REQ-034 With macro LINK_SEQ_AUTO_RESTART_EN defined, channel_up low in LINKED clears retry_cnt and moves to RESET_LINK.
REQ-035 Without LINK_SEQ_AUTO_RESTART_EN, channel_up low in LINKED moves directly to FAIL.

Verification
REQ-036 The bench shall use RESET_CYCLES=8, UP_TIMEOUT=64, TEST_CYCLES=32, MAX_RETRIES=2, ERR_LIMIT=1.
REQ-037 Clean bring-up: start, channel_up rises 10 cycles into WAIT_UP, no errors -> LINKED, pass=1, err_cnt=0, retry_cnt=0.
REQ-038 Timeout: channel_up held 0 -> three 64-cycle WAIT_UP windows -> FAIL, retry_cnt=2, link_reset=1.
REQ-039 Errors: 20 frame_error pulses in every TEST window -> FAIL, err_cnt=15 (saturated), retry_cnt=2.
REQ-040 Link drop: channel_up low for 1 cycle at TEST cycle 5 of the first attempt -> RESET_LINK, retry_cnt=1; a clean second attempt -> LINKED.
REQ-041 LINKED drop: channel_up falls -> RESET_LINK with LINK_SEQ_AUTO_RESTART_EN defined; FAIL with the macro undefined.
REQ-042 Async reset: peripheral_aresetn pulled low mid-TEST between clock edges -> all outputs take reset values at once; a later start repeats REQ-037.
